// File: rtl/ttl_video_pkg.sv
// Shared types and default 640x480@60 timing for the TTL video transmitter
// and any video_driver users that need the same geometry.
package ttl_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_HFP    = 16;
    localparam int DEF_HSW    = 96;
    localparam int DEF_HBP    = 48;
    localparam int DEF_VFP    = 10;
    localparam int DEF_VSW    = 2;
    localparam int DEF_VBP    = 33;

    // Counter widths sized for an 800 x 525 total raster.
    localparam int HC_W = 10;
    localparam int VC_W = 10;
    localparam int Y_W  = 9;

    // Colour-bar palette: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b111;
            3'd1:    code = 3'b110;
            3'd2:    code = 3'b011;
            3'd3:    code = 3'b010;
            3'd4:    code = 3'b101;
            3'd5:    code = 3'b100;
            3'd6:    code = 3'b001;
            default: code = 3'b000;
        endcase
        return {{8{code[2]}}, {8{code[1]}}, {8{code[0]}}};
    endfunction

endpackage

// File: rtl/ttl_timing_gen.sv
// Raster counters and raw (undelayed, ungated) sync / active-area decode.
module ttl_timing_gen
    import ttl_video_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int HFP    = DEF_HFP,
    parameter int HSW    = DEF_HSW,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VSW    = DEF_VSW,
    parameter int VBP    = DEF_VBP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    output logic [HC_W-1:0] hc,
    output logic [Y_W-1:0]  vc_lo,
    output logic            in_active,
    output logic            hsync_n,
    output logic            vsync_n,
    output logic            at_origin,
    output logic            frame_last
);

    localparam int H_TOTAL = WIDTH + HFP + HSW + HBP;
    localparam int V_TOTAL = HEIGHT + VFP + VSW + VBP;

    localparam logic [HC_W-1:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT    = 10'(WIDTH);
    localparam logic [HC_W-1:0] HS_START = 10'(WIDTH + HFP);
    localparam logic [HC_W-1:0] HS_END   = 10'(WIDTH + HFP + HSW);
    localparam logic [VC_W-1:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT    = 10'(HEIGHT);
    localparam logic [VC_W-1:0] VS_START = 10'(HEIGHT + VFP);
    localparam logic [VC_W-1:0] VS_END   = 10'(HEIGHT + VFP + VSW);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (advance) begin
            if (hc_q == H_MAX) begin
                hc_d = '0;
                vc_d = (vc_q == V_MAX) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc         = hc_q;
    assign vc_lo      = vc_q[Y_W-1:0];
    assign in_active  = (hc_q < H_ACT) && (vc_q < V_ACT);
    assign hsync_n    = !((hc_q >= HS_START) && (hc_q < HS_END));
    assign vsync_n    = !((vc_q >= VS_START) && (vc_q < VS_END));
    assign at_origin  = (hc_q == '0) && (vc_q == '0);
    assign frame_last = (hc_q == H_MAX) && (vc_q == V_MAX);

endmodule

// File: rtl/ttl_video_tx.sv
// TTL parallel video transmitter: run/drain FSM, 2-stage pixel pipeline to pins.
// Optional colour-bar generator enabled by defining TTL_TX_TESTPATTERN_EN.
module ttl_video_tx
    import ttl_video_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int HFP    = DEF_HFP,
    parameter int HSW    = DEF_HSW,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VSW    = DEF_VSW,
    parameter int VBP    = DEF_VBP
) (
    input  logic       PixelClock,
    input  logic       reset,
    input  logic       enable,
`ifdef TTL_TX_TESTPATTERN_EN
    input  logic       test_mode,
`endif
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic       pix_req,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_start,
    output logic       busy,
    output logic [7:0] ttl_r,
    output logic [7:0] ttl_g,
    output logic [7:0] ttl_b,
    output logic       ttl_hs,
    output logic       ttl_vs,
    output logic       ttl_de,
    output logic       ttl_clk
);

    tx_state_e state_q, state_d;

    logic [HC_W-1:0] hc;
    logic [Y_W-1:0]  vc_lo;
    logic            in_active;
    logic            hsync_n;
    logic            vsync_n;
    logic            at_origin;
    logic            frame_last;
    logic            active;

    logic        de_p1_q, de_p1_d;
    logic        hs_p1_q, hs_p1_d;
    logic        vs_p1_q, vs_p1_d;
    logic        ttl_de_q, ttl_de_d;
    logic        ttl_hs_q, ttl_hs_d;
    logic        ttl_vs_q, ttl_vs_d;
    logic [23:0] ttl_rgb_q, ttl_rgb_d;
    logic [23:0] pixel_in;

    ttl_timing_gen #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .HFP   (HFP),
        .HSW   (HSW),
        .HBP   (HBP),
        .VFP   (VFP),
        .VSW   (VSW),
        .VBP   (VBP)
    ) u_timing (
        .clk       (PixelClock),
        .rst_n     (reset),
        .advance   (active),
        .hc        (hc),
        .vc_lo     (vc_lo),
        .in_active (in_active),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .at_origin (at_origin),
        .frame_last(frame_last)
    );

    // DRAIN finishes the current frame; re-enabling resumes it seamlessly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)          state_d = ST_RUN;
                else if (frame_last) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PixelClock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign active      = (state_q != ST_IDLE);
    assign pix_req     = active && in_active;
    assign x           = pix_req ? hc : '0;
    assign y           = pix_req ? vc_lo : '0;
    assign frame_start = active && at_origin;
    assign busy        = active;

`ifdef TTL_TX_TESTPATTERN_EN
    localparam int BAR_W = WIDTH / 8;

    logic [2:0]  bar_idx;
    logic [23:0] pat_p1_q, pat_p1_d;

    // Bar colour is looked up from the request column so it lines up with r/g/b.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hc >= 10'(k * BAR_W)) bar_idx = 3'(k);
        end
        pat_p1_d = bar_rgb(bar_idx);
    end

    always_ff @(posedge PixelClock or negedge reset) begin
        if (!reset) pat_p1_q <= '0;
        else        pat_p1_q <= pat_p1_d;
    end
`endif

    always_comb begin
        de_p1_d  = pix_req;
        hs_p1_d  = !active || hsync_n;
        vs_p1_d  = !active || vsync_n;
        ttl_de_d = de_p1_q;
        ttl_hs_d = hs_p1_q;
        ttl_vs_d = vs_p1_q;
        pixel_in = {r, g, b};
`ifdef TTL_TX_TESTPATTERN_EN
        if (test_mode) pixel_in = pat_p1_q;
`endif
        ttl_rgb_d = de_p1_q ? pixel_in : '0;
    end

    always_ff @(posedge PixelClock or negedge reset) begin
        if (!reset) begin
            de_p1_q   <= 1'b0;
            hs_p1_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            ttl_de_q  <= 1'b0;
            ttl_hs_q  <= 1'b1;
            ttl_vs_q  <= 1'b1;
            ttl_rgb_q <= '0;
        end else begin
            de_p1_q   <= de_p1_d;
            hs_p1_q   <= hs_p1_d;
            vs_p1_q   <= vs_p1_d;
            ttl_de_q  <= ttl_de_d;
            ttl_hs_q  <= ttl_hs_d;
            ttl_vs_q  <= ttl_vs_d;
            ttl_rgb_q <= ttl_rgb_d;
        end
    end

    assign ttl_r   = ttl_rgb_q[23:16];
    assign ttl_g   = ttl_rgb_q[15:8];
    assign ttl_b   = ttl_rgb_q[7:0];
    assign ttl_de  = ttl_de_q;
    assign ttl_hs  = ttl_hs_q;
    assign ttl_vs  = ttl_vs_q;
    assign ttl_clk = ~PixelClock;

endmodule

// File: tb/tb_ttl_video_tx.sv
// Self-checking bench for ttl_video_tx on a reduced raster, against a
// frame-position reference model with a 2-cycle pin pipeline.
module tb_ttl_video_tx;

    localparam int TW = 128, TH = 40, THFP = 4, THSW = 8, THBP = 6;
    localparam int TVFP = 2, TVSW = 2, TVBP = 2;
    localparam int HT = TW + THFP + THSW + THBP;
    localparam int VT = TH + TVFP + TVSW + TVBP;
    localparam int FRAME = HT * VT;

    logic       PixelClock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       test_mode = 1'b0;
    logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
    logic       pix_req, frame_start, busy;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] ttl_r, ttl_g, ttl_b;
    logic       ttl_hs, ttl_vs, ttl_de, ttl_clk;

    ttl_video_tx #(
        .WIDTH(TW), .HEIGHT(TH), .HFP(THFP), .HSW(THSW), .HBP(THBP),
        .VFP(TVFP), .VSW(TVSW), .VBP(TVBP)
    ) dut (
        .PixelClock (PixelClock),
        .reset      (reset),
        .enable     (enable),
`ifdef TTL_TX_TESTPATTERN_EN
        .test_mode  (test_mode),
`endif
        .r          (r),
        .g          (g),
        .b          (b),
        .pix_req    (pix_req),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .busy       (busy),
        .ttl_r      (ttl_r),
        .ttl_g      (ttl_g),
        .ttl_b      (ttl_b),
        .ttl_hs     (ttl_hs),
        .ttl_vs     (ttl_vs),
        .ttl_de     (ttl_de),
        .ttl_clk    (ttl_clk)
    );

    always #5 PixelClock = ~PixelClock;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int c0       = 0;
    int rgb_mode = 0;

    // Reference model: frame position plus a pending-stop flag
    bit          m_active, m_stop;
    int          m_pos;
    bit          m_de1, m_hs1, m_vs1;
    int          m_x1, m_y1;
    bit          m_pin_de, m_pin_hs, m_pin_vs;
    logic [23:0] m_pin_rgb;
    bit          e_req, e_fs, e_busy;
    int          e_x, e_y;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic void model_outputs();
        int hc, vc;
        hc = m_pos % HT;
        vc = m_pos / HT;
        e_req  = m_active && hc < TW && vc < TH;
        e_x    = e_req ? hc : 0;
        e_y    = e_req ? vc : 0;
        e_fs   = m_active && m_pos == 0;
        e_busy = m_active;
    endfunction

    function automatic void model_clear();
        m_active = 0; m_stop = 0; m_pos = 0;
        m_de1 = 0; m_hs1 = 1; m_vs1 = 1; m_x1 = 0; m_y1 = 0;
        m_pin_de = 0; m_pin_hs = 1; m_pin_vs = 1; m_pin_rgb = '0;
        model_outputs();
    endfunction

    // Advance one clock, update the model, then answer the previous request.
    task automatic tick();
        int hc, vc;
        bit req, hs_n, vs_n;
        @(posedge PixelClock);
        hc   = m_pos % HT;
        vc   = m_pos / HT;
        req  = m_active && hc < TW && vc < TH;
        hs_n = !(m_active && hc >= TW + THFP && hc < TW + THFP + THSW);
        vs_n = !(m_active && vc >= TH + TVFP && vc < TH + TVFP + TVSW);
        if (!reset) begin
            model_clear();
        end else begin
            m_pin_de = m_de1; m_pin_hs = m_hs1; m_pin_vs = m_vs1;
            if (!m_de1)         m_pin_rgb = '0;
            else if (test_mode) m_pin_rgb = bars[m_x1 / (TW / 8)];
            else                m_pin_rgb = {r, g, b};
            m_de1 = req; m_hs1 = hs_n; m_vs1 = vs_n;
            m_x1 = req ? hc : 0;
            m_y1 = req ? vc : 0;
            if (m_active) begin
                if (!enable && m_stop && m_pos == FRAME - 1) m_active = 0;
                m_stop = !enable;
                m_pos  = (m_pos + 1) % FRAME;
            end else if (enable) begin
                m_active = 1; m_pos = 0; m_stop = 0;
            end
            model_outputs();
        end
        #1;
        cyc++;
        if (rgb_mode == 0) begin
            r = m_x1[7:0]; g = m_y1[7:0]; b = 8'hA5;
        end else begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 0; enable = 0; rgb_mode = 0;
        repeat (3) tick();
        n_checks++;
        if ({pix_req, x, y, frame_start, busy} !== 22'd0) begin
            n_fails++;
            $display("[TB] FAIL reset_ctrl: got req=%b x=%0d y=%0d fs=%b busy=%b want all 0",
                     pix_req, x, y, frame_start, busy);
        end
        n_checks++;
        if ({ttl_r, ttl_g, ttl_b, ttl_de} !== 25'd0) begin
            n_fails++;
            $display("[TB] FAIL reset_pins: got rgb=%h%h%h de=%b want 0", ttl_r, ttl_g, ttl_b, ttl_de);
        end
        n_checks++;
        if ({ttl_hs, ttl_vs} !== 2'b11) begin
            n_fails++;
            $display("[TB] FAIL reset_syncs: got hs=%b vs=%b want 1 1", ttl_hs, ttl_vs);
        end
        n_checks++;
        if (ttl_clk !== ~PixelClock) begin
            n_fails++;
            $display("[TB] FAIL ttl_clk_hi: got %b want %b", ttl_clk, ~PixelClock);
        end
        #5;
        n_checks++;
        if (ttl_clk !== ~PixelClock) begin
            n_fails++;
            $display("[TB] FAIL ttl_clk_lo: got %b want %b", ttl_clk, ~PixelClock);
        end
    endtask

    task automatic test_start();
        reset = 1; enable = 1;
        tick();
        c0 = cyc;
        n_checks++;
        if ({pix_req, x, y, frame_start, busy} !== {1'b1, 10'd0, 9'd0, 1'b1, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL start_first_req: got req=%b x=%0d y=%0d fs=%b busy=%b want 1 0 0 1 1",
                     pix_req, x, y, frame_start, busy);
        end
        n_checks++;
        if (ttl_de !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL start_de_c1: got %b want 0", ttl_de);
        end
        tick();
        n_checks++;
        if (ttl_de !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL start_de_c2: got %b want 0", ttl_de);
        end
        tick();
        n_checks++;
        if (ttl_de !== 1'b1 || x !== 10'd2) begin
            n_fails++;
            $display("[TB] FAIL start_de_c3: got de=%b x=%0d want de=1 x=2", ttl_de, x);
        end
    endtask

    task automatic test_frame_timing();
        int  rel, period;
        int  de_fall = -1, hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
        bit  p_de, p_hs, p_vs, done;
        p_de = ttl_de; p_hs = ttl_hs; p_vs = ttl_vs; done = 0; period = -1;
        rgb_mode = 0;
        for (int i = 0; i < FRAME + 20 && !done; i++) begin
            tick();
            rel = cyc - c0;
            if (frame_start) begin done = 1; period = rel; end
            if (p_de && !ttl_de && de_fall < 0) de_fall = rel;
            if (p_hs && !ttl_hs && hs_fall < 0) hs_fall = rel;
            if (!p_hs && ttl_hs && hs_rise < 0) hs_rise = rel;
            if (p_vs && !ttl_vs && vs_fall < 0) vs_fall = rel;
            if (!p_vs && ttl_vs && vs_rise < 0) vs_rise = rel;
            p_de = ttl_de; p_hs = ttl_hs; p_vs = ttl_vs;
            if (rel == 37 * HT + 100 + 2) begin
                n_checks++;
                if ({ttl_r, ttl_g, ttl_b} !== 24'h6425A5) begin
                    n_fails++;
                    $display("[TB] FAIL pixel_100_37: got %h%h%h want 6425a5", ttl_r, ttl_g, ttl_b);
                end
            end
            if (rel == 37 * HT + TW + 3 + 2 || rel == (TH + 1) * HT + 10 + 2) begin
                n_checks++;
                if ({ttl_r, ttl_g, ttl_b} !== 24'h0) begin
                    n_fails++;
                    $display("[TB] FAIL blank_rgb: got %h%h%h want 0 at rel %0d", ttl_r, ttl_g, ttl_b, rel);
                end
            end
        end
        n_checks++;
        if (period != FRAME) begin
            n_fails++;
            $display("[TB] FAIL frame_period: got %0d want %0d", period, FRAME);
        end
        n_checks++;
        if (de_fall != 2 + TW) begin
            n_fails++;
            $display("[TB] FAIL de_width: got fall at %0d want %0d", de_fall, 2 + TW);
        end
        n_checks++;
        if (hs_fall != 2 + TW + THFP || hs_rise != 2 + TW + THFP + THSW) begin
            n_fails++;
            $display("[TB] FAIL hsync_window: got %0d..%0d want %0d..%0d", hs_fall, hs_rise,
                     2 + TW + THFP, 2 + TW + THFP + THSW);
        end
        n_checks++;
        if (vs_fall != 2 + (TH + TVFP) * HT || vs_rise != vs_fall + TVSW * HT) begin
            n_fails++;
            $display("[TB] FAIL vsync_window: got %0d..%0d want %0d..%0d", vs_fall, vs_rise,
                     2 + (TH + TVFP) * HT, 2 + (TH + TVFP + TVSW) * HT);
        end
    endtask

    task automatic test_model_random(input int n);
        rgb_mode = 1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            tick();
            n_checks++;
            if ({pix_req, x, y, frame_start, busy} !== {e_req, 10'(e_x), 9'(e_y), e_fs, e_busy}) begin
                n_fails++;
                $display("[TB] FAIL rand_ctrl: got req=%b x=%0d y=%0d fs=%b busy=%b want %b %0d %0d %b %b",
                         pix_req, x, y, frame_start, busy, e_req, e_x, e_y, e_fs, e_busy);
            end
            n_checks++;
            if ({ttl_de, ttl_hs, ttl_vs} !== {m_pin_de, m_pin_hs, m_pin_vs}) begin
                n_fails++;
                $display("[TB] FAIL rand_syncs: got de/hs/vs=%b%b%b want %b%b%b",
                         ttl_de, ttl_hs, ttl_vs, m_pin_de, m_pin_hs, m_pin_vs);
            end
            n_checks++;
            if ({ttl_r, ttl_g, ttl_b} !== m_pin_rgb) begin
                n_fails++;
                $display("[TB] FAIL rand_rgb: got %h%h%h want %h", ttl_r, ttl_g, ttl_b, m_pin_rgb);
            end
        end
    endtask

    task automatic test_drain();
        int c, rel;
        bit found, gap;
        rgb_mode = 0; enable = 1; found = 0;
        for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
            tick();
            if (frame_start) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fails++;
            $display("[TB] FAIL drain_sync: got no frame_start want one within %0d", 2 * FRAME + 4);
        end
        c = cyc;
        while (cyc - c < 20 * HT) tick();
        enable = 0;
        rel = -1;
        for (int i = 0; i < 2 * FRAME && rel < 0; i++) begin
            tick();
            if (!busy) rel = cyc - c;
        end
        n_checks++;
        if (rel != FRAME) begin
            n_fails++;
            $display("[TB] FAIL drain_end: got idle at %0d want %0d", rel, FRAME);
        end
        n_checks++;
        if ({pix_req, frame_start, ttl_hs, ttl_vs} !== 4'b0011) begin
            n_fails++;
            $display("[TB] FAIL drain_idle: got req=%b fs=%b hs=%b vs=%b want 0 0 1 1",
                     pix_req, frame_start, ttl_hs, ttl_vs);
        end
        repeat (12) tick();
        n_checks++;
        if ({busy, x, y, ttl_de, ttl_r, ttl_g, ttl_b, ttl_hs, ttl_vs} !== {45'd0, 2'b11}) begin
            n_fails++;
            $display("[TB] FAIL idle_flush: got busy=%b x=%0d y=%0d de=%b rgb=%h%h%h hs=%b vs=%b",
                     busy, x, y, ttl_de, ttl_r, ttl_g, ttl_b, ttl_hs, ttl_vs);
        end
        enable = 1;
        tick();
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL restart_fs: got %b want 1", frame_start);
        end
        c = cyc; gap = 0; found = 0; rel = -1;
        while (cyc - c < 20 * HT) tick();
        enable = 0;
        while (cyc - c < 30 * HT) begin
            tick();
            if (!busy) gap = 1;
        end
        enable = 1;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (!busy) gap = 1;
            if (frame_start) begin found = 1; rel = cyc - c; end
        end
        n_checks++;
        if (rel != FRAME || gap) begin
            n_fails++;
            $display("[TB] FAIL drain_resume: got period=%0d gap=%b want %0d gap=0", rel, gap, FRAME);
        end
    endtask

    task automatic test_reset_midframe();
        bit found;
        found = 0; enable = 1;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (pix_req && x == 10'd100 && y == 9'd10) found = 1;
        end
        n_checks++;
        if (!found || ttl_de !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL mid_reach: got found=%b de=%b want 1 1", found, ttl_de);
        end
        #2;
        reset = 0;
        #1;
        n_checks++;
        if ({pix_req, x, y, frame_start, busy, ttl_r, ttl_g, ttl_b, ttl_de, ttl_hs, ttl_vs}
            !== {47'd0, 2'b11}) begin
            n_fails++;
            $display("[TB] FAIL mid_reset: got req=%b x=%0d y=%0d fs=%b busy=%b rgb=%h%h%h de=%b hs=%b vs=%b",
                     pix_req, x, y, frame_start, busy, ttl_r, ttl_g, ttl_b, ttl_de, ttl_hs, ttl_vs);
        end
        model_clear();
        enable = 0;
        tick();
        reset = 1;
        tick();
    endtask

`ifdef TTL_TX_TESTPATTERN_EN
    task automatic test_pattern();
        int c, rel;
        test_mode = 1; rgb_mode = 1; enable = 1;
        tick();
        c = cyc;
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL pat_start: got fs=%b want 1", frame_start);
        end
        for (int i = 0; i < TW + 4; i++) begin
            tick();
            rel = cyc - c;
            if (rel >= 2 && rel < 2 + TW) begin
                n_checks++;
                if ({ttl_r, ttl_g, ttl_b} !== m_pin_rgb || ttl_de !== 1'b1) begin
                    n_fails++;
                    $display("[TB] FAIL pat_bar: got %h%h%h de=%b want %h de=1 at x=%0d",
                             ttl_r, ttl_g, ttl_b, ttl_de, m_pin_rgb, rel - 2);
                end
                if (rel < 2 + TW / 8) begin
                    n_checks++;
                    if ({ttl_r, ttl_g, ttl_b} !== 24'hFFFFFF) begin
                        n_fails++;
                        $display("[TB] FAIL pat_white: got %h%h%h want ffffff", ttl_r, ttl_g, ttl_b);
                    end
                end
                if (rel >= 2 + 7 * (TW / 8)) begin
                    n_checks++;
                    if ({ttl_r, ttl_g, ttl_b} !== 24'h000000) begin
                        n_fails++;
                        $display("[TB] FAIL pat_black: got %h%h%h want 000000", ttl_r, ttl_g, ttl_b);
                    end
                end
            end
        end
        test_mode = 0;
    endtask
`endif

    initial begin
        $display("[TB] ttl_video_tx bench, raster %0dx%0d, frame %0d cycles", HT, VT, FRAME);
        model_clear();
        test_reset();
        test_start();
        test_frame_timing();
        test_model_random(6000);
        test_drain();
        test_reset_midframe();
`ifdef TTL_TX_TESTPATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
